// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared constants for the multi-channel DDS generator: waveform
//               mode codes, DAC command/frame geometry, sequencer state
//               encoding and the sine-table entry function used to build the
//               waveform ROM contents at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    // Waveform mode codes as written through cfg_mode
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_SINE = 2'd1;
    localparam logic [1:0] MODE_SAW  = 2'd2;
    localparam logic [1:0] MODE_SQR  = 2'd3;

    // DAC command nibble: write input register and update output
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

    localparam int FRAME_W = 32;
    localparam int DATA_W  = 12;

    // Frame sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_LOAD     = 3'd1;
    localparam state_t ST_ROMWAIT  = 3'd2;
    localparam state_t ST_CS_SETUP = 3'd3;
    localparam state_t ST_SHIFT    = 3'd4;
    localparam state_t ST_CS_HOLD  = 3'd5;
    localparam state_t ST_NEXT     = 3'd6;

    // Entry k of a full-period, offset-binary sine table of 'depth' entries:
    // round(2047.5 + 2047.5*sin(2*pi*k/depth)). The angle is folded into the
    // first quadrant so that the zero crossings evaluate to exactly 0.0 and
    // the half-way ties round consistently; the sine itself is a Taylor series
    // that is accurate far below one LSB over [0, pi/2].
    function automatic logic [DATA_W-1:0] sine_entry(input int k, input int depth);
        real x;
        real term;
        real s;
        real v;
        int  quarter;
        int  q;
        int  j;
        quarter = depth / 4;
        q       = k / quarter;
        j       = k % quarter;
        if (q == 1 || q == 3) begin
            j = quarter - j;
        end
        x    = 6.283185307179586 * j / depth;
        s    = 0.0;
        term = x;
        for (int n = 1; n < 20; n += 2) begin
            s    = s + term;
            term = -term * x * x / real'((n + 1) * (n + 2));
        end
        if (q >= 2) begin
            v = 2047.5 - 2047.5 * s;
        end else begin
            v = 2047.5 + 2047.5 * s;
        end
        return DATA_W'($rtoi(v + 0.5));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dds_generator_wave_rom.sv
`default_nettype none
// ============================================================================
// Module      : wave_rom
// Description : Synchronous-read sine table, 2^ROM_AW entries x 12 bit,
//               one full period in unsigned offset binary. Contents are
//               computed at elaboration time from dds_pkg::sine_entry.
// Ports       : clk    - system clock
//               i_addr - table address (phase index)
//               o_q    - table entry, valid one cycle after i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module wave_rom
    import dds_pkg::*;
#(
    parameter int ROM_AW = 8
) (
    input  logic              clk,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [DATA_W-1:0] o_q
);

    localparam int c_DEPTH = 1 << ROM_AW;

    logic [DATA_W-1:0] w_table [c_DEPTH];
    logic [DATA_W-1:0] r_q;

    generate
        for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_table
            localparam logic [DATA_W-1:0] c_VAL = sine_entry(gi, c_DEPTH);
            assign w_table[gi] = c_VAL;
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_q <= w_table[i_addr];
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/dds_generator.sv
`default_nettype none
// ============================================================================
// Module      : dds_generator
// Description : Multi-channel DDS waveform generator driving an LTC2624-style
//               serial DAC. A free-running divider produces one sample tick
//               every DIV cycles; each accepted tick advances every channel's
//               phase accumulator and sends one 32-bit frame per enabled
//               channel, round-robin 0..CHANNELS-1.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               cfg_we/ch/ftw/mode  - per-channel tuning word and mode write
//               spi_mosi, spi_sck   - DAC data (MSB first) and clock
//               dac_cs, dac_clr     - DAC chip select / clear, active-low
//               busy                - a tick's frames are in progress
//               overrun             - sticky: a tick was dropped while busy
// Revision    : 1.0 - initial release
// ============================================================================
module dds_generator
    import dds_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV      = 50000,
    parameter int ACC_W    = 24,
    parameter int ROM_AW   = 8,
    parameter int SCK_DIV  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [1:0]       cfg_mode,
    output logic             spi_mosi,
    output logic             spi_sck,
    output logic             dac_cs,
    output logic             dac_clr,
    output logic             busy,
    output logic             overrun
);

    localparam int c_CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_DIVC_W = (SCK_DIV > 0) ? $clog2(2 * SCK_DIV) : 1;

    // ------------------------------------------------------------------
    // Sample tick divider
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;

    assign w_tick = (r_tick_cnt == c_CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Channel configuration and phase accumulators
    // ------------------------------------------------------------------
    state_t             r_state;
    logic               w_accept;
    logic [CHANNELS-1:0] w_cfg_hit;
    logic [ACC_W-1:0]   w_ftw_eff [CHANNELS];
    logic [ACC_W-1:0]   r_ftw     [CHANNELS];
    logic [1:0]         r_mode    [CHANNELS];
    logic [ACC_W-1:0]   r_acc     [CHANNELS];

    assign w_accept = w_tick && (r_state == ST_IDLE);

    // A write landing on the tick cycle must already steer that tick's
    // accumulator step, so the adder sees the incoming word directly.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cfg
            assign w_cfg_hit[gi] = cfg_we && (cfg_ch == 2'(gi));
            assign w_ftw_eff[gi] = w_cfg_hit[gi] ? cfg_ftw : r_ftw[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_ftw[i]  <= '0;
                r_mode[i] <= MODE_OFF;
                r_acc[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_cfg_hit[i]) begin
                    r_ftw[i]  <= cfg_ftw;
                    r_mode[i] <= cfg_mode;
                end
                if (w_accept) begin
                    r_acc[i] <= r_acc[i] + w_ftw_eff[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample generation
    // ------------------------------------------------------------------
    logic [1:0]         r_ch;
    logic [1:0]         r_cur_mode;
    logic [ROM_AW-1:0]  w_rom_addr;
    logic [DATA_W-1:0]  w_rom_q;
    logic [DATA_W-1:0]  w_sample;
    logic [FRAME_W-1:0] w_frame;

    // Accumulators only move on an accepted tick, so the address is stable
    // from LOAD through ROMWAIT.
    assign w_rom_addr = r_acc[r_ch][ACC_W-1 -: ROM_AW];

    wave_rom #(
        .ROM_AW (ROM_AW)
    ) u_wave_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_q    (w_rom_q)
    );

    always_comb begin
        w_sample = '0;
        case (r_cur_mode)
            MODE_SINE: w_sample = w_rom_q;
            MODE_SAW:  w_sample = r_acc[r_ch][ACC_W-1 -: DATA_W];
            MODE_SQR:  w_sample = {DATA_W{r_acc[r_ch][ACC_W-1]}};
            default:   w_sample = '0;
        endcase
    end

    assign w_frame = {8'h00, CMD_WRITE_UPDATE, 2'b00, r_ch, w_sample, 4'h0};

    // ------------------------------------------------------------------
    // Frame sequencer and SPI shifter
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0]  r_shift;
    logic [c_DIVC_W-1:0] r_div_cnt;
    logic [4:0]          r_bit_cnt;
    logic                r_mosi;
    logic                r_sck;
    logic                r_cs_n;
    logic                r_busy;
    logic                r_overrun;
    logic                r_dac_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_cur_mode <= MODE_OFF;
            r_shift    <= '0;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_mosi     <= 1'b0;
            r_sck      <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            r_dac_clr  <= 1'b0;
        end else begin
            r_dac_clr <= 1'b1;
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        r_busy  <= 1'b1;
                        r_ch    <= '0;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    // Mode is latched here so a config write during the
                    // frame cannot change the sample type mid-frame.
                    r_cur_mode <= r_mode[r_ch];
                    if (r_mode[r_ch] == MODE_OFF) begin
                        r_state <= ST_NEXT;
                    end else begin
                        r_state <= ST_ROMWAIT;
                    end
                end

                ST_ROMWAIT: begin
                    r_shift   <= w_frame;
                    r_mosi    <= w_frame[FRAME_W-1];
                    r_cs_n    <= 1'b0;
                    r_div_cnt <= '0;
                    r_state   <= ST_CS_SETUP;
                end

                ST_CS_SETUP: begin
                    if (r_div_cnt == c_DIVC_W'(SCK_DIV - 1)) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_sck     <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (r_div_cnt == c_DIVC_W'(SCK_DIV - 1)) begin
                        r_div_cnt <= '0;
                        if (r_sck) begin
                            // Falling edge: present the next bit, or end the
                            // frame after the 32nd bit; the low half of the
                            // last period is timed by CS_HOLD.
                            r_sck <= 1'b0;
                            if (r_bit_cnt == 5'd31) begin
                                r_mosi  <= 1'b0;
                                r_state <= ST_CS_HOLD;
                            end else begin
                                r_mosi    <= r_shift[FRAME_W-2];
                                r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_sck <= 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                ST_CS_HOLD: begin
                    // First SCK_DIV cycles: CS held low after the last
                    // falling edge; next SCK_DIV cycles: CS high gap.
                    if (r_div_cnt == c_DIVC_W'(SCK_DIV - 1)) begin
                        r_cs_n <= 1'b1;
                    end
                    if (r_div_cnt == c_DIVC_W'(2 * SCK_DIV - 1)) begin
                        r_div_cnt <= '0;
                        r_state   <= ST_NEXT;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                ST_NEXT: begin
                    if (r_ch == 2'(CHANNELS - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= ST_LOAD;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_mosi = r_mosi;
    assign spi_sck  = r_sck;
    assign dac_cs   = r_cs_n;
    assign dac_clr  = r_dac_clr;
    assign busy     = r_busy;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dds_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_generator
// Description : Self-checking bench for dds_generator. A serial monitor
//               reassembles DAC frames; a behavioural model predicts, per
//               accepted tick, the phase of every channel and the frames the
//               enabled channels must produce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_generator;
    import dds_pkg::*;

    localparam int CHANNELS = 4;
    localparam int DIV      = 400;
    localparam int ACC_W    = 24;
    localparam int ROM_AW   = 8;
    localparam int SCK_DIV  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_ch = '0;
    logic [ACC_W-1:0] cfg_ftw = '0;
    logic [1:0]       cfg_mode = '0;
    logic             spi_mosi;
    logic             spi_sck;
    logic             dac_cs;
    logic             dac_clr;
    logic             busy;
    logic             overrun;

    dds_generator #(
        .CHANNELS (CHANNELS),
        .DIV      (DIV),
        .ACC_W    (ACC_W),
        .ROM_AW   (ROM_AW),
        .SCK_DIV  (SCK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_ftw  (cfg_ftw),
        .cfg_mode (cfg_mode),
        .spi_mosi (spi_mosi),
        .spi_sck  (spi_sck),
        .dac_cs   (dac_cs),
        .dac_clr  (dac_clr),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle index since reset release; a tick occurs where it hits DIV-1
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Serial monitor
    // ------------------------------------------------------------------
    logic [31:0] rx_q[$];
    int          rx_n[$];
    logic [31:0] mon_sr = '0;
    int          mon_n = 0;
    int          n_glitch = 0;
    logic        mon_sck_q = 1'b0;
    logic        mon_cs_q = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mon_n  = 0;
            mon_sr = '0;
        end else begin
            if (dac_cs && spi_sck) n_glitch++;
            if (!dac_cs && spi_sck && !mon_sck_q) begin
                mon_sr = {mon_sr[30:0], spi_mosi};
                mon_n++;
            end
            if (dac_cs && !mon_cs_q) begin
                rx_q.push_back(mon_sr);
                rx_n.push_back(mon_n);
                mon_n = 0;
            end
        end
        mon_sck_q = spi_sck;
        mon_cs_q  = dac_cs;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] m_acc  [CHANNELS];
    logic [ACC_W-1:0] m_ftw  [CHANNELS];
    logic [1:0]       m_mode [CHANNELS];
    logic [31:0]      exp_q[$];

    function automatic logic [11:0] ref_sine(input int k);
        real v;
        v = 2047.5 + 2047.5 * $sin(2.0 * 3.141592653589793 * k / real'(1 << ROM_AW));
        return 12'($rtoi(v + 0.5));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_acc[c]  = '0;
            m_ftw[c]  = '0;
            m_mode[c] = MODE_OFF;
        end
        exp_q.delete();
    endtask

    task automatic model_tick();
        logic [11:0] d;
        for (int c = 0; c < CHANNELS; c++) m_acc[c] = m_acc[c] + m_ftw[c];
        for (int c = 0; c < CHANNELS; c++) begin
            if (m_mode[c] != MODE_OFF) begin
                case (m_mode[c])
                    MODE_SINE: d = ref_sine(int'(m_acc[c] >> (ACC_W - ROM_AW)));
                    MODE_SAW:  d = 12'(m_acc[c] >> (ACC_W - 12));
                    default:   d = (m_acc[c] >= (ACC_W'(1) << (ACC_W - 1))) ? 12'hFFF : 12'h000;
                endcase
                exp_q.push_back({8'h00, 4'b0011, 4'(c), d, 4'h0});
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cfg(input int ch, input logic [ACC_W-1:0] ftw, input logic [1:0] mode);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_ftw = ftw; cfg_mode = mode;
        if (ch < CHANNELS) begin
            m_ftw[ch]  = ftw;
            m_mode[ch] = mode;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic write_at_tick(input int ch, input logic [ACC_W-1:0] ftw, input logic [1:0] mode);
        bit ok;
        ok = 0;
        for (int i = 0; i < DIV + 2; i++) begin
            @(negedge clk);
            if (cyc % DIV == DIV - 1) begin
                ok = 1;
                break;
            end
        end
        check("tick_align", 32'(ok), 32'd1);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_ftw = ftw; cfg_mode = mode;
        m_ftw[ch]  = ftw;
        m_mode[ch] = mode;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, output bit ok);
        ok = 0;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clk);
            if (busy === lvl) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_group(input string tag);
        bit ok;
        wait_busy(1'b1, ok);
        check({tag, "_start"}, 32'(ok), 32'd1);
        model_tick();
        wait_busy(1'b0, ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        check({tag, "_nframes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_frame"}, rx_q.pop_front(), exp_q.pop_front());
            check({tag, "_nbits"}, 32'(rx_n.pop_front()), 32'd32);
        end
        rx_q.delete();
        rx_n.delete();
        exp_q.delete();
    endtask

    task automatic all_off();
        for (int c = 0; c < CHANNELS; c++) cfg(c, '0, MODE_OFF);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        bit ok;
        int a;
        int b;
        model_reset();

        // Reset behaviour
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(dac_cs), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_clr", 32'(dac_clr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("clr_release", 32'(dac_clr), 32'd1);

        // Sine on ch2 with zero tuning word: table entry 0
        cfg(2, '0, MODE_SINE);
        run_group("sine0");

        // Sawtooth on ch0
        cfg(2, '0, MODE_OFF);
        cfg(0, 24'h100000, MODE_SAW);
        for (int i = 0; i < 16; i++) run_group("saw");

        // Square on ch1, ch0 off
        cfg(0, 24'h100000, MODE_OFF);
        cfg(1, 24'h400000, MODE_SQR);
        for (int i = 0; i < 8; i++) run_group("square");

        // Config write coinciding with the tick steers that tick
        write_at_tick(1, 24'h123456, MODE_SAW);
        run_group("same_cycle");

        // Randomised: two channels active, random modes and tuning words
        for (int r = 0; r < 6; r++) begin
            all_off();
            a = $urandom_range(CHANNELS - 1, 0);
            b = (a + $urandom_range(CHANNELS - 1, 1)) % CHANNELS;
            cfg(a, ACC_W'($urandom()), 2'($urandom_range(3, 1)));
            cfg(b, ACC_W'($urandom()), 2'($urandom_range(3, 1)));
            for (int i = 0; i < 4; i++) run_group("random");
        end

        // Overrun: all four channels exceed the tick budget
        check("ovr_before", 32'(overrun), 32'd0);
        for (int c = 0; c < CHANNELS; c++) cfg(c, ACC_W'($urandom()), 2'($urandom_range(3, 1)));
        for (int i = 0; i < 3; i++) run_group("overrun");
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a frame
        all_off();
        cfg(0, 24'h0A0000, MODE_SAW);
        wait_busy(1'b1, ok);
        check("mid_busy", 32'(ok), 32'd1);
        ok = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (mon_n == 15) begin
                ok = 1;
                break;
            end
        end
        check("mid_bit15", 32'(ok), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_cs", 32'(dac_cs), 32'd1);
        check("mid_sck", 32'(spi_sck), 32'd0);
        check("mid_busy_clr", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_ovr_clr", 32'(overrun), 32'd0);
        model_reset();
        rx_q.delete();
        rx_n.delete();
        rst = 1'b0;
        cfg(3, ACC_W'($urandom()), MODE_SINE);
        cfg(0, 24'h0A0000, MODE_SQR);
        for (int i = 0; i < 3; i++) run_group("post_rst");

        check("sck_idle_low", 32'(n_glitch), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
